// File: rtl/cache_pkg.sv
// Shared types and helpers for the direct-mapped write-back cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WB_REQ,
    S_RF_REQ,
    S_RF_WAIT,
    S_RESPOND,
    S_FLUSH_SCAN,
    S_FLUSH_WB
  } state_e;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_INDEX_W = 2;
  localparam int DEF_CNT_W   = 16;

  function automatic int lines_of(input int index_w);
    return 1 << index_w;
  endfunction

  function automatic int tag_w_of(input int addr_w, input int index_w);
    return addr_w - index_w;
  endfunction

  localparam int LINES = lines_of(DEF_INDEX_W);
  localparam int TAG_W = tag_w_of(DEF_ADDR_W, DEF_INDEX_W);

endpackage

// File: rtl/cache_line_store.sv
// Tag/data/valid/dirty arrays: one full-line write port, asynchronous read at the same index.
module cache_line_store #(
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx_i,
  input  logic               we_i,
  input  logic [TAG_W-1:0]   wtag_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic               wvalid_i,
  input  logic               wdirty_i,
  output logic [TAG_W-1:0]   rtag_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               rvalid_o,
  output logic               rdirty_o
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0][TAG_W-1:0]  tag_q;
  logic [LINES-1:0][DATA_W-1:0] data_q;
  logic [LINES-1:0]             valid_q;
  logic [LINES-1:0]             dirty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      tag_q[idx_i]   <= wtag_i;
      data_q[idx_i]  <= wdata_i;
      valid_q[idx_i] <= wvalid_i;
      dirty_q[idx_i] <= wdirty_i;
    end
  end

  assign rtag_o   = tag_q[idx_i];
  assign rdata_o  = data_q[idx_i];
  assign rvalid_o = valid_q[idx_i];
  assign rdirty_o = dirty_q[idx_i];

endmodule

// File: rtl/cache_ctrl_wb.sv
// Direct-mapped write-back/write-allocate cache controller: request FSM, refill/writeback,
// flush scan and saturating hit/miss statistics.
module cache_ctrl_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int INDEX_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_hit,
  input  logic              flush,
  output logic              busy,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int TAG_W = tag_w_of(ADDR_W, INDEX_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_e             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [INDEX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]   hit_q, hit_d, miss_q, miss_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag, rtag, st_tag;
  logic [DATA_W-1:0]  rdata, st_data;
  logic               rvalid, rdirty, st_we, st_valid, st_dirty, hit, flushing;

  assign flushing = (state_q == S_FLUSH_SCAN) || (state_q == S_FLUSH_WB);
  assign idx      = flushing ? ptr_q : cmd_q.addr[INDEX_W-1:0];
  assign req_tag  = cmd_q.addr[ADDR_W-1:INDEX_W];
  assign hit      = rvalid && (rtag == req_tag);

  cache_line_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_store (
    .clk      (clk),
    .rst      (rst),
    .idx_i    (idx),
    .we_i     (st_we),
    .wtag_i   (st_tag),
    .wdata_i  (st_data),
    .wvalid_i (st_valid),
    .wdirty_i (st_dirty),
    .rtag_o   (rtag),
    .rdata_o  (rdata),
    .rvalid_o (rvalid),
    .rdirty_o (rdirty)
  );

  assign req_ready  = ena && !flush && (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // Memory command is a pure function of the frozen state, so it stays stable while stalled.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state_q)
      S_WB_REQ, S_FLUSH_WB: begin
        mem_req_valid = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = {rtag, idx};
        mem_wdata     = rdata;
      end
      S_RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = cmd_q.addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    ptr_d     = ptr_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    st_we     = 1'b0;
    st_tag    = rtag;
    st_data   = rdata;
    st_valid  = rvalid;
    st_dirty  = rdirty;
    rsp_valid = 1'b0;
    rsp_hit   = 1'b0;
    rsp_rdata = '0;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            state_d = S_FLUSH_SCAN;
            ptr_d   = '0;
          end else if (req_valid) begin
            cmd_d   = '{we: req_we, addr: req_addr, wdata: req_wdata};
            state_d = S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (hit) begin
            rsp_valid = 1'b1;
            rsp_hit   = 1'b1;
            rsp_rdata = cmd_q.we ? cmd_q.wdata : rdata;
            st_we     = cmd_q.we;
            st_data   = cmd_q.wdata;
            st_dirty  = 1'b1;
            hit_d     = (hit_q == CNT_MAX) ? hit_q : hit_q + CNT_W'(1);
            state_d   = S_IDLE;
          end else begin
            miss_d  = (miss_q == CNT_MAX) ? miss_q : miss_q + CNT_W'(1);
            state_d = (rvalid && rdirty) ? S_WB_REQ : S_RF_REQ;
          end
        end
        S_WB_REQ: begin
          if (mem_req_ready) begin
            st_we    = 1'b1;
            st_dirty = 1'b0;
            state_d  = S_RF_REQ;
          end
        end
        S_RF_REQ: if (mem_req_ready) state_d = S_RF_WAIT;
        S_RF_WAIT: begin
          if (mem_rsp_valid) begin
            st_we    = 1'b1;
            st_tag   = req_tag;
            st_data  = cmd_q.we ? cmd_q.wdata : mem_rdata;
            st_valid = 1'b1;
            st_dirty = cmd_q.we;
            state_d  = S_RESPOND;
          end
        end
        S_RESPOND: begin
          rsp_valid = 1'b1;
          rsp_rdata = rdata;
          state_d   = S_IDLE;
        end
        S_FLUSH_SCAN: begin
          if (rvalid && rdirty) begin
            state_d = S_FLUSH_WB;
          end else begin
            st_we    = 1'b1;
            st_valid = 1'b0;
            st_dirty = 1'b0;
            state_d  = (&ptr_q) ? S_IDLE : S_FLUSH_SCAN;
            ptr_d    = ptr_q + INDEX_W'(1);
          end
        end
        S_FLUSH_WB: begin
          if (mem_req_ready) begin
            st_we    = 1'b1;
            st_valid = 1'b0;
            st_dirty = 1'b0;
            state_d  = (&ptr_q) ? S_IDLE : S_FLUSH_SCAN;
            ptr_d    = ptr_q + INDEX_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      ptr_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ptr_q   <= ptr_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

endmodule
